mysystem_pio_key: RTL and testbench
===================================

# mysystem_pio_key

Avalon-MM input PIO slave for the board push-buttons. Synchronizes and optionally debounces WIDTH external inputs, latches selected edges into a sticky edge-capture register, and raises a level interrupt to the Nios II when any captured, unmasked bit is set. It is the input-side counterpart of the LED output PIO and sits on the same system interconnect with zero-wait-state, combinational readdata.

## Interface
- WIDTH, 4: number of key inputs (1..32)
- EDGE_TYPE, 0: captured edge; 0 = falling, 1 = rising, 2 = any
- DEBOUNCE_CYCLES, 500000: stable-cycle count required before a debounced bit changes (10 ms at 50 MHz); must be ≥ 2
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous key inputs, idle high
- readdata  out  32  read data, combinational from address
- irq  out  1  level interrupt, active high

## Operation
- Register map (word addresses): 0 DATA (RO, debounced input level); 2 IRQMASK (RW); 3 EDGECAPTURE (R, write-1-to-clear). Other addresses read 0 and ignore writes. Upper 32-WIDTH readdata bits are 0.
- Write strobe = chipselect && !write_n; reads have no side effects.
- Input path: two-flop synchronizer per bit → debounce → edge detect (debounced vs. one-cycle-delayed debounced).
- Debounce per bit: counter clears whenever synced value equals debounced value; otherwise it increments; on the edge where the mismatch has been seen DEBOUNCE_CYCLES consecutive cycles, debounced takes the synced value and counter clears. A single-cycle agreement mid-count restarts the count.
- Edge capture: bit i set when the selected edge occurs on debounced bit i; remains set until software writes 1 to bit i at address 3. Writing 0 leaves the bit unchanged.
- Simultaneous clear and new edge on the same bit: set wins (bit stays 1).
- irq = |(EDGECAPTURE & IRQMASK), combinational from registers.
- Reset: synchronizer, delayed and debounced registers → all ones (no spurious edge after reset with idle-high keys); counters, IRQMASK, EDGECAPTURE → 0; irq → 0; readdata → DATA value (all ones) when address = 0.
- Reset assertion mid-debounce or with pending edges discards all state; no edge is generated on release.

## Timing
- Read latency 0: readdata valid in the same cycle as address.
- Write takes effect on the next rising clk edge.
- in_port change at edge 0 (stable thereafter): synced at edge 2; debounced (and DATA) at edge 2+DEBOUNCE_CYCLES; EDGECAPTURE and irq at edge 3+DEBOUNCE_CYCLES.
- Without debounce: DATA at edge 2, EDGECAPTURE/irq at edge 3.
- Clearing EDGECAPTURE drops irq one cycle after the write edge-captured, i.e. visible after the write's clock edge.

## Configuration
- PIO_KEY_DEBOUNCE_EN defined: debounce stage and counters instantiated as above.
- Not defined: debounced = synchronizer output; DEBOUNCE_CYCLES ignored; no counters synthesized.

## Structure
- Shared package: register address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and EDGE_TYPE encodings (EDGE_FALL, EDGE_RISE, EDGE_ANY).
- One sub-module: pio_key_debounce (single bit, parameter DEBOUNCE_CYCLES, counter width $clog2(DEBOUNCE_CYCLES+1)), generated WIDTH times.

## Test plan
- Reset then read addr 0/2/3 -> 0x0000000F, 0x0, 0x0; irq = 0.
- DEBOUNCE_CYCLES=8, EDGE_TYPE=0: in_port[1] 1→0 at edge 0 -> DATA = 0xD at edge 10, EDGECAPTURE = 0x2 at edge 11; irq stays 0 with IRQMASK=0.
- Write IRQMASK=0x2, then edge on key 1 -> irq = 1; write 0x2 to addr 3 -> EDGECAPTURE = 0, irq = 0 next cycle; write 0x0 to addr 3 earlier -> no change.
- Bounce: in_port[0] toggles every 3 cycles for 40 cycles then settles low -> exactly one capture, DATA[0] changes 10 cycles after last toggle.
- Clear write to addr 3 bit 2 on the same edge key 2 captures -> EDGECAPTURE[2] remains 1.
- EDGE_TYPE=2, press and release key 3 with clears between -> two captures; reset_n pulsed mid-count -> all registers at reset values, no capture after release.

Source files
------------

// File: rtl/mysystem_pio_key_pkg.sv
// Shared constants for the push-button input PIO.
// Register word addresses and edge-select encodings.
package mysystem_pio_key_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/mysystem_pio_key_debounce.sv
// Single-bit debouncer for one synchronized key input.
// Counters exist only when PIO_KEY_DEBOUNCE_EN is defined.
module pio_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic synced,
  output logic debounced
);

`ifdef PIO_KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Follow synced only after it disagrees for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      debounced <= 1'b1;
    end else if (synced == debounced) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt       <= '0;
      debounced <= synced;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  logic unused_db;

  assign debounced = synced;
  assign unused_db = clk ^ reset_n ^ (DEBOUNCE_CYCLES > 1);
`endif

endmodule

// File: rtl/mysystem_pio_key.sv
// Avalon-MM input PIO for push-buttons with edge capture and irq.
// Debounce is enabled by defining PIO_KEY_DEBOUNCE_EN.
module mysystem_pio_key
  import mysystem_pio_key_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] ecap;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Two-flop synchronizer; idle-high reset avoids a fake press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    pio_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .synced   (sync2[i]),
      .debounced(deb[i])
    );
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) deb_d <= '1;
    else          deb_d <= deb;
  end

  // Select which transitions of the debounced level count.
  always_comb begin
    edges = deb_d & ~deb;
    if (EDGE_TYPE == EDGE_RISE)
      edges = ~deb_d & deb;
    else if (EDGE_TYPE == EDGE_ANY)
      edges = deb_d ^ deb;
  end

  // Write-1-to-clear mask for the edge-capture register.
  always_comb begin
    clr = '0;
    if (wr && address == ADDR_EDGECAP)
      clr = writedata[WIDTH-1:0];
  end

  // Mask register and sticky capture; a new edge beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
      ecap <= '0;
    end else begin
      if (wr && address == ADDR_IRQMASK)
        mask <= writedata[WIDTH-1:0];
      ecap <= (ecap & ~clr) | edges;
    end
  end

  assign irq = |(ecap & mask);

  // Zero-wait combinational read mux.
  always_comb begin
    readdata = '0;
    unique case (1'b1)
      (address == ADDR_DATA):    readdata[WIDTH-1:0] = deb;
      (address == ADDR_IRQMASK): readdata[WIDTH-1:0] = mask;
      (address == ADDR_EDGECAP): readdata[WIDTH-1:0] = ecap;
      default:                   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mysystem_pio_key.sv
// Directed bench for mysystem_pio_key (falling and any-edge units).
// Latencies follow PIO_KEY_DEBOUNCE_EN with DEBOUNCE_CYCLES=8.
module tb_mysystem_pio_key;

`ifdef PIO_KEY_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] rd0;
  logic [31:0] rd2;
  logic        irq0;
  logic        irq2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mysystem_pio_key #(
    .WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  mysystem_pio_key #(
    .WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)
  ) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    in_port = 4'hF;
    step(3);
    reset_n = 1'b1;
    step(2);
    address = 3'd0; #1;
    total++;
    if (rd0 !== 32'hF) begin
      $display("FAIL reset_data got=%h exp=%h", rd0, 32'hF); bad++;
    end
    address = 3'd2; #1;
    total++;
    if (rd0 !== 32'h0) begin
      $display("FAIL reset_mask got=%h exp=%h", rd0, 32'h0); bad++;
    end
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h0) begin
      $display("FAIL reset_ecap got=%h exp=%h", rd0, 32'h0); bad++;
    end
    address = 3'd1; #1;
    total++;
    if (rd0 !== 32'h0) begin
      $display("FAIL reset_addr1 got=%h exp=%h", rd0, 32'h0); bad++;
    end
    total++;
    if (irq0 !== 1'b0) begin
      $display("FAIL reset_irq got=%b exp=0", irq0); bad++;
    end
  endtask

  task automatic test_fall_capture;
    in_port[1] = 1'b0;
    step(1 + DB);
    address = 3'd0; #1;
    total++;
    if (rd0 !== 32'hF) begin
      $display("FAIL data_early got=%h exp=%h", rd0, 32'hF); bad++;
    end
    step(1);
    address = 3'd0; #1;
    total++;
    if (rd0 !== 32'hD) begin
      $display("FAIL data_fall got=%h exp=%h", rd0, 32'hD); bad++;
    end
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h0) begin
      $display("FAIL ecap_early got=%h exp=%h", rd0, 32'h0); bad++;
    end
    step(1);
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h2) begin
      $display("FAIL ecap_fall got=%h exp=%h", rd0, 32'h2); bad++;
    end
    total++;
    if (irq0 !== 1'b0) begin
      $display("FAIL irq_masked got=%b exp=0", irq0); bad++;
    end
  endtask

  task automatic test_irq;
    wr(3'd2, 32'h2);
    address = 3'd2; #1;
    total++;
    if (rd0 !== 32'h2) begin
      $display("FAIL mask_rd got=%h exp=%h", rd0, 32'h2); bad++;
    end
    total++;
    if (irq0 !== 1'b1) begin
      $display("FAIL irq_set got=%b exp=1", irq0); bad++;
    end
    wr(3'd3, 32'h0);
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h2 || irq0 !== 1'b1) begin
      $display("FAIL clr_zero got=%h/%b exp=2/1", rd0, irq0); bad++;
    end
    wr(3'd3, 32'h2);
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0) begin
      $display("FAIL clr_one got=%h/%b exp=0/0", rd0, irq0); bad++;
    end
    in_port[1] = 1'b1;
    step(3 + DB + 2);
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h0) begin
      $display("FAIL rise_ignored got=%h exp=%h", rd0, 32'h0); bad++;
    end
    total++;
    if (rd2 !== 32'h2) begin
      $display("FAIL any_rise got=%h exp=%h", rd2, 32'h2); bad++;
    end
    wr(3'd3, 32'hF);
    in_port[1] = 1'b0;
    step(2 + DB);
    total++;
    if (irq0 !== 1'b0) begin
      $display("FAIL irq_early got=%b exp=0", irq0); bad++;
    end
    step(1);
    total++;
    if (irq0 !== 1'b1) begin
      $display("FAIL irq_edge got=%b exp=1", irq0); bad++;
    end
    in_port[1] = 1'b1;
    step(3 + DB + 2);
    wr(3'd3, 32'hF);
    wr(3'd2, 32'h0);
  endtask

  task automatic test_bounce;
    logic [31:0] exp_mid;
    exp_mid = (DB > 0) ? 32'h0 : 32'h1;
    for (int i = 0; i < 12; i++) begin
      in_port[0] = ~in_port[0];
      step(3);
    end
    address = 3'd3; #1;
    total++;
    if (rd0 !== exp_mid) begin
      $display("FAIL bounce_mid got=%h exp=%h", rd0, exp_mid); bad++;
    end
    wr(3'd3, 32'hF);
    in_port[0] = 1'b0;
    step(1 + DB);
    address = 3'd0; #1;
    total++;
    if (rd0[0] !== 1'b1) begin
      $display("FAIL bounce_hold got=%b exp=1", rd0[0]); bad++;
    end
    step(1);
    address = 3'd0; #1;
    total++;
    if (rd0 !== 32'hE) begin
      $display("FAIL bounce_data got=%h exp=%h", rd0, 32'hE); bad++;
    end
    step(1);
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h1) begin
      $display("FAIL bounce_cap got=%h exp=%h", rd0, 32'h1); bad++;
    end
    wr(3'd3, 32'h1);
    step(DB + 4);
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h0) begin
      $display("FAIL bounce_once got=%h exp=%h", rd0, 32'h0); bad++;
    end
    in_port[0] = 1'b1;
    step(3 + DB + 2);
    wr(3'd3, 32'hF);
  endtask

  task automatic test_clear_collision;
    in_port[2] = 1'b0;
    step(2 + DB);
    wr(3'd3, 32'h4);
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h4) begin
      $display("FAIL set_wins got=%h exp=%h", rd0, 32'h4); bad++;
    end
    in_port[2] = 1'b1;
    step(3 + DB + 2);
    wr(3'd3, 32'hF);
  endtask

  task automatic test_any_edge;
    in_port[3] = 1'b0;
    step(3 + DB);
    address = 3'd3; #1;
    total++;
    if (rd2 !== 32'h8 || rd0 !== 32'h8) begin
      $display("FAIL any_press got=%h/%h exp=8/8", rd2, rd0); bad++;
    end
    wr(3'd3, 32'hF);
    in_port[3] = 1'b1;
    step(3 + DB);
    address = 3'd3; #1;
    total++;
    if (rd2 !== 32'h8 || rd0 !== 32'h0) begin
      $display("FAIL any_release got=%h/%h exp=8/0", rd2, rd0); bad++;
    end
    wr(3'd2, 32'hF);
    in_port[3] = 1'b0;
    step(4);
    reset_n = 1'b0;
    in_port = 4'hF;
    step(2);
    address = 3'd2; #1;
    total++;
    if (rd0 !== 32'h0 || rd2 !== 32'h0) begin
      $display("FAIL rst_mask got=%h/%h exp=0/0", rd0, rd2); bad++;
    end
    address = 3'd3; #1;
    total++;
    if (rd2 !== 32'h0 || irq2 !== 1'b0) begin
      $display("FAIL rst_ecap got=%h/%b exp=0/0", rd2, irq2); bad++;
    end
    reset_n = 1'b1;
    step(3 + DB + 3);
    address = 3'd3; #1;
    total++;
    if (rd0 !== 32'h0 || rd2 !== 32'h0) begin
      $display("FAIL rst_nocap got=%h/%h exp=0/0", rd0, rd2); bad++;
    end
    address = 3'd0; #1;
    total++;
    if (rd2 !== 32'hF) begin
      $display("FAIL rst_data got=%h exp=%h", rd2, 32'hF); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_fall_capture();
    test_irq();
    test_bounce();
    test_clear_collision();
    test_any_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
